// File: rtl/bpf_pipeline_sequencer_if.sv
// Control bundle between the BPF pipeline sequencer (slave) and the stage controllers / host (master).
// Counter outputs exist only when BPF_SEQ_PERF_CNT_EN is defined.
interface bpf_pipeline_sequencer_if
`ifdef BPF_SEQ_PERF_CNT_EN
    #(parameter int CNT_WIDTH = 32)
`endif
    ;
    logic start;
    logic done_ack;
    logic stage1_rd_A;
    logic stage1_rd_X;
    logic stage1_wr_A;
    logic stage1_wr_X;
    logic stage1_is_ret;
    logic stage2_branch_taken;
    logic stage2_mem_rd;
    logic mem_rd_ack;

    logic stage0_en;
    logic stage1_en;
    logic stage2_en;
    logic stage3_en;
    logic stage1_valid;
    logic stage2_valid;
    logic stage3_valid;
    logic stage1_stalled;
    logic pc_load;
    logic busy;
    logic done;

`ifdef BPF_SEQ_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] inst_retired;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_count;
`endif

    modport master (
`ifdef BPF_SEQ_PERF_CNT_EN
        input  inst_retired, stall_cycles, flush_count,
`endif
        output start, done_ack,
        output stage1_rd_A, stage1_rd_X, stage1_wr_A, stage1_wr_X, stage1_is_ret,
        output stage2_branch_taken, stage2_mem_rd, mem_rd_ack,
        input  stage0_en, stage1_en, stage2_en, stage3_en,
        input  stage1_valid, stage2_valid, stage3_valid,
        input  stage1_stalled, pc_load, busy, done
    );

    modport slave (
`ifdef BPF_SEQ_PERF_CNT_EN
        output inst_retired, stall_cycles, flush_count,
`endif
        input  start, done_ack,
        input  stage1_rd_A, stage1_rd_X, stage1_wr_A, stage1_wr_X, stage1_is_ret,
        input  stage2_branch_taken, stage2_mem_rd, mem_rd_ack,
        output stage0_en, stage1_en, stage2_en, stage3_en,
        output stage1_valid, stage2_valid, stage3_valid,
        output stage1_stalled, pc_load, busy, done
    );
endinterface

// File: rtl/bpf_pipeline_sequencer.sv
// Purpose: stage valids, A/X RAW scoreboard, branch flush, packet-memory wait and RET drain for the 4-stage BPF CPU.
// Latency: first fetch the cycle after start is sampled; enables are combinational from registered state (stage 3 at start+4).
// Backpressure: RAW hazard holds stage 1 + fetch; pending packet read freezes stages 0-2 while stage 3 retires. BPF_SEQ_PERF_CNT_EN adds counters.
module bpf_pipeline_sequencer
`ifdef BPF_SEQ_PERF_CNT_EN
    #(parameter int CNT_WIDTH = 32)
`endif
    (
    input  logic                     clk,
    input  logic                     rst,
    bpf_pipeline_sequencer_if.slave  sq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic v1_q;
    logic v2_q;
    logic v3_q;
    logic sb_a2_q;
    logic sb_a3_q;
    logic sb_x2_q;
    logic sb_x3_q;
    logic ret2_q;
    logic ret3_q;

    logic mem_stall;
    logic hazard;
    logic flush;
    logic ret_in_s1;
    logic fetch_en;
    logic adv_s2;
    logic adv_s3;

    // Hazard and branch inputs are unqualified by the controllers, so every use is gated by a valid bit here.
    assign mem_stall = v2_q & sq.stage2_mem_rd & ~sq.mem_rd_ack;
    assign hazard    = v1_q & ((sq.stage1_rd_A & (sb_a2_q | sb_a3_q)) |
                               (sq.stage1_rd_X & (sb_x2_q | sb_x3_q)));
    assign flush     = v2_q & sq.stage2_branch_taken & ~mem_stall;
    assign ret_in_s1 = v1_q & sq.stage1_is_ret;

    assign adv_s3 = v2_q & ~mem_stall;
    assign adv_s2 = v1_q & ~hazard & ~mem_stall & ~flush;

    // A flush overrides hazard and RET holds: the PC must still step to the branch target.
    assign fetch_en = (state_q == S_RUN) & ~mem_stall & (flush | (~hazard & ~ret_in_s1));

    assign sq.stage0_en      = fetch_en;
    assign sq.stage1_en      = fetch_en;
    assign sq.stage2_en      = adv_s2;
    assign sq.stage3_en      = adv_s3;
    assign sq.stage1_valid   = v1_q;
    assign sq.stage2_valid   = v2_q;
    assign sq.stage3_valid   = v3_q;
    assign sq.stage1_stalled = hazard & ~flush;
    assign sq.pc_load        = flush;
    assign sq.busy           = (state_q == S_RUN) | (state_q == S_DRAIN);
    assign sq.done           = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (sq.start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // adv_s2 already excludes a flush, so a squashed RET never starts a drain.
                if (ret_in_s1 & adv_s2) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (v3_q & ret3_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (sq.done_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stage 1: a fetched word enters unless squashed; a departing instruction with no refill leaves a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
        end else if (flush) begin
            v1_q <= 1'b0;
        end else if (fetch_en) begin
            v1_q <= 1'b1;
        end else if (adv_s2) begin
            v1_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_q    <= 1'b0;
            sb_a2_q <= 1'b0;
            sb_x2_q <= 1'b0;
            ret2_q  <= 1'b0;
        end else if (!mem_stall) begin
            v2_q    <= adv_s2;
            sb_a2_q <= sq.stage1_wr_A & adv_s2;
            sb_x2_q <= sq.stage1_wr_X & adv_s2;
            ret2_q  <= sq.stage1_is_ret & adv_s2;
        end
    end

    // Stage 3 always retires; behind a packet-memory wait it receives a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v3_q    <= 1'b0;
            sb_a3_q <= 1'b0;
            sb_x3_q <= 1'b0;
            ret3_q  <= 1'b0;
        end else begin
            v3_q    <= adv_s3;
            sb_a3_q <= sb_a2_q & adv_s3;
            sb_x3_q <= sb_x2_q & adv_s3;
            ret3_q  <= ret2_q & adv_s3;
        end
    end

`ifdef BPF_SEQ_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] inst_retired_q;
    logic [CNT_WIDTH-1:0] stall_cycles_q;
    logic [CNT_WIDTH-1:0] flush_count_q;
    logic                 run_start;

    assign run_start = (state_q == S_IDLE) & sq.start;

    // Saturating counters, restarted with each program run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_retired_q <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else if (run_start) begin
            inst_retired_q <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (v3_q && !(&inst_retired_q)) begin
                inst_retired_q <= inst_retired_q + CNT_ONE;
            end
            if ((hazard || mem_stall) && !(&stall_cycles_q)) begin
                stall_cycles_q <= stall_cycles_q + CNT_ONE;
            end
            if (flush && !(&flush_count_q)) begin
                flush_count_q <= flush_count_q + CNT_ONE;
            end
        end
    end

    assign sq.inst_retired = inst_retired_q;
    assign sq.stall_cycles = stall_cycles_q;
    assign sq.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_bpf_pipeline_sequencer.sv
// Bench for bpf_pipeline_sequencer: directed scenarios then random programs, all checked against an
// instruction-level model that tracks which program word occupies each stage.
module tb_bpf_pipeline_sequencer;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    typedef struct packed {
        logic       rd_a;
        logic       rd_x;
        logic       wr_a;
        logic       wr_x;
        logic       ret;
        logic       br;
        logic       mem;
        logic [6:0] tgt;
    } inst_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bpf_pipeline_sequencer_if sq ();

    bpf_pipeline_sequencer dut (
        .clk (clk),
        .rst (rst),
        .sq  (sq)
    );

    inst_t prog [0:127];

    // Model state: program index held by each stage (-1 = empty), PC, run state, wait age, counters.
    int m_s1, m_s2, m_s3, m_pc, m_st, m_wait;
    int m_ret, m_stl, m_fl;

    int n_assert = 0;
    int n_fail   = 0;
    int ack_mode = 0;
    int tcyc     = 0;
    int start_cyc;
    int first_done;
    int obs_fetch, obs_stall, obs_pcload, obs_hold;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, tcyc);
        end
    endtask

    function automatic logic [10:0] dut_vec();
        return {sq.stage0_en, sq.stage1_en, sq.stage2_en, sq.stage3_en,
                sq.stage1_valid, sq.stage2_valid, sq.stage3_valid,
                sq.stage1_stalled, sq.pc_load, sq.busy, sq.done};
    endfunction

    function automatic inst_t at(input int idx);
        inst_t     r;
        logic [13:0] g;
        if (idx < 0) begin
            g = 14'($urandom);
            r = g;
        end else if (idx > 127) begin
            r = '0;
            r.ret = 1'b1;
        end else begin
            r = prog[idx];
        end
        return r;
    endfunction

    task automatic m_reset();
        m_s1 = -1; m_s2 = -1; m_s3 = -1;
        m_pc = 0; m_st = M_IDLE; m_wait = 0;
        m_ret = 0; m_stl = 0; m_fl = 0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 128; i++) prog[i] = '0;
        prog[127].ret = 1'b1;
    endtask

    task automatic gen_prog();
        for (int i = 0; i < 128; i++) begin
            prog[i]      = '0;
            prog[i].rd_a = ($urandom_range(0, 2) == 0);
            prog[i].rd_x = ($urandom_range(0, 2) == 0);
            prog[i].wr_a = ($urandom_range(0, 2) == 0);
            prog[i].wr_x = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) begin
                prog[i].ret = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
                prog[i].br  = 1'b1;
                prog[i].tgt = 7'((i + 1 + $urandom_range(0, 6) > 127) ? 127 : i + 1 + $urandom_range(0, 6));
            end else if ($urandom_range(0, 4) == 0) begin
                prog[i].mem = 1'b1;
            end
        end
        prog[127]     = '0;
        prog[127].ret = 1'b1;
    endtask

    // One clock: drive stage inputs from the model's occupants, check outputs at negedge, advance model.
    task automatic step();
        inst_t i1, i2, i3;
        logic  v1, v2, v3, ack, mw, blk, tk, adv, fe, rt, st_in, da_in;
        int    ns1, ns2, ns3, npc, nst;
        i1 = at(m_s1); i2 = at(m_s2); i3 = at(m_s3);
        v1 = (m_s1 >= 0); v2 = (m_s2 >= 0); v3 = (m_s3 >= 0);
        if (ack_mode == 1 && v2 && i2.mem) ack = (m_wait >= 3);
        else ack = 1'($urandom);
        sq.stage1_rd_A = i1.rd_a; sq.stage1_rd_X = i1.rd_x;
        sq.stage1_wr_A = i1.wr_a; sq.stage1_wr_X = i1.wr_x;
        sq.stage1_is_ret = i1.ret;
        sq.stage2_branch_taken = i2.br; sq.stage2_mem_rd = i2.mem;
        sq.mem_rd_ack = ack;
        st_in = sq.start; da_in = sq.done_ack;

        mw  = v2 && i2.mem && !ack;
        blk = v1 && ((i1.rd_a && ((v2 && i2.wr_a) || (v3 && i3.wr_a))) ||
                     (i1.rd_x && ((v2 && i2.wr_x) || (v3 && i3.wr_x))));
        tk  = v2 && i2.br && !mw;
        adv = v1 && !blk && !mw && !tk;
        fe  = (m_st == M_RUN) && !mw && (tk || (!blk && !(v1 && i1.ret)));
        rt  = v2 && !mw;

        @(negedge clk);
        chk("stage_outputs", dut_vec(),
            {fe, fe, adv, rt, v1, v2, v3, blk && !tk, tk,
             (m_st == M_RUN || m_st == M_DRAIN), (m_st == M_DONE)});
        obs_fetch  += int'(sq.stage0_en);
        obs_stall  += int'(sq.stage1_stalled);
        obs_pcload += int'(sq.pc_load);
        obs_hold   += int'(sq.stage2_valid && !sq.stage3_en);
        if (sq.done && first_done < 0) first_done = tcyc;
        tcyc++;
        @(posedge clk);
        #1;

        ns3 = rt ? m_s2 : -1;
        ns2 = adv ? m_s1 : (mw ? m_s2 : -1);
        ns1 = tk ? -1 : (fe ? m_pc : (adv ? -1 : m_s1));
        npc = tk ? int'(i2.tgt) : (fe ? m_pc + 1 : m_pc);
        nst = m_st;
        case (m_st)
            M_IDLE:  if (st_in) begin nst = M_RUN; npc = 0; end
            M_RUN:   if (v1 && i1.ret && adv) nst = M_DRAIN;
            M_DRAIN: if (v3 && i3.ret) nst = M_DONE;
            default: if (da_in) nst = M_IDLE;
        endcase
        if (m_st == M_IDLE && st_in) begin
            m_ret = 0; m_stl = 0; m_fl = 0;
        end else begin
            m_ret += int'(v3);
            m_stl += int'(blk || mw);
            m_fl  += int'(tk);
        end
        m_wait = mw ? m_wait + 1 : 0;
        m_s1 = ns1; m_s2 = ns2; m_s3 = ns3; m_pc = npc; m_st = nst;
    endtask

    task automatic run_prog(input string name, input int max_cyc);
        int   cyc;
        logic seen_done;
        obs_fetch = 0; obs_stall = 0; obs_pcload = 0; obs_hold = 0;
        first_done = -1;
        start_cyc  = tcyc;
        sq.start = 1'b1; sq.done_ack = 1'($urandom);
        step();
        cyc = 1;
        seen_done = 1'b0;
        while (!(seen_done && m_st == M_IDLE) && cyc < max_cyc) begin
            sq.start    = 1'($urandom);
            sq.done_ack = 1'($urandom);
            step();
            cyc++;
            if (m_st == M_DONE) seen_done = 1'b1;
        end
        sq.start = 1'b0; sq.done_ack = 1'b0;
        chk({name, "_completes"}, {62'd0, seen_done, m_st == M_IDLE}, 64'd3);
`ifdef BPF_SEQ_PERF_CNT_EN
        chk({name, "_inst_retired"}, 64'(sq.inst_retired), 64'(m_ret));
        chk({name, "_stall_cycles"}, 64'(sq.stall_cycles), 64'(m_stl));
        chk({name, "_flush_count"},  64'(sq.flush_count),  64'(m_fl));
`endif
    endtask

    initial begin
        rst = 1'b0;
        sq.start = 1'b0; sq.done_ack = 1'b0;
        sq.stage1_rd_A = 1'b0; sq.stage1_rd_X = 1'b0;
        sq.stage1_wr_A = 1'b0; sq.stage1_wr_X = 1'b0; sq.stage1_is_ret = 1'b0;
        sq.stage2_branch_taken = 1'b0; sq.stage2_mem_rd = 1'b0; sq.mem_rd_ack = 1'b0;
        m_reset();
        #1;
        chk("reset_outputs", 64'(dut_vec()), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // RET as the first instruction: single fetch, done five cycles after start.
        clear_prog();
        prog[0].ret = 1'b1;
        run_prog("t1_ret", 200);
        chk("t1_done_latency", 64'(first_done - start_cyc), 64'd5);
        chk("t1_fetch_cycles", 64'(obs_fetch), 64'd1);

        // Write A then read A: two stall cycles.
        clear_prog();
        prog[0].wr_a = 1'b1; prog[1].rd_a = 1'b1; prog[2].ret = 1'b1;
        run_prog("t2_raw", 200);
        chk("t2_stall_cycles", 64'(obs_stall), 64'd2);

        // X-register dependency with one independent instruction in between: one stall cycle.
        clear_prog();
        prog[0].wr_x = 1'b1; prog[2].rd_x = 1'b1; prog[3].ret = 1'b1;
        run_prog("t2b_raw_x", 200);
        chk("t2b_stall_cycles", 64'(obs_stall), 64'd1);

        // Taken branch squashes a RET sitting in stage 1.
        clear_prog();
        prog[0].br = 1'b1; prog[0].tgt = 7'd3; prog[1].ret = 1'b1; prog[3].ret = 1'b1;
        run_prog("t3_branch", 200);
        chk("t3_pc_load_pulses", 64'(obs_pcload), 64'd1);

        // Packet read acknowledged three cycles late.
        clear_prog();
        prog[0].mem = 1'b1; prog[2].ret = 1'b1;
        ack_mode = 1;
        run_prog("t4_mem", 200);
        chk("t4_hold_cycles", 64'(obs_hold), 64'd3);
        ack_mode = 0;

        // Asynchronous reset during a RAW stall, then a clean rerun.
        clear_prog();
        prog[0].wr_a = 1'b1; prog[1].rd_a = 1'b1; prog[2].ret = 1'b1;
        obs_stall = 0;
        sq.start = 1'b1;
        step();
        sq.start = 1'b0;
        for (int k = 0; k < 20 && obs_stall == 0; k++) step();
        chk("t5_stalled_before_reset", 64'(sq.stage1_stalled), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t5_outputs_in_reset", 64'(dut_vec()), 64'd0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_prog("t5_restart", 200);
        chk("t5_restart_stalls", 64'(obs_stall), 64'd2);

`ifdef BPF_SEQ_PERF_CNT_EN
        clear_prog();
        prog[0].wr_a = 1'b1; prog[1].rd_a = 1'b1;
        prog[2].br = 1'b1; prog[2].tgt = 7'd4; prog[3].ret = 1'b1; prog[4].ret = 1'b1;
        run_prog("t6_perf", 200);
        chk("t6_inst_retired_exact", 64'(sq.inst_retired), 64'd4);
        chk("t6_stall_cycles_exact", 64'(sq.stall_cycles), 64'd2);
        chk("t6_flush_count_exact",  64'(sq.flush_count),  64'd1);
`endif

        for (int p = 0; p < 40; p++) begin
            gen_prog();
            run_prog("random", 3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
